fft8_input_framer: RTL and testbench
====================================

# fft8_input_framer

Upstream stage of the 8-point combinational FFT core. Accepts a serial stream of complex Q15 samples over a valid/ready handshake and assembles groups of 8 into a frame. Frames sit in a ping-pong pair of register banks and are presented in parallel, natural order (sample k → slot k), to the FFT inputs x0..x7. A frame is held stable until the consumer takes it, while the other bank fills.

## Interface
- DW, 16, sample component width (signed, two's complement, Q15 at DW=16)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  framer can accept a sample this cycle
- s_re  in  DW  sample real part
- s_im  in  DW  sample imaginary part
- s_last  in  1  marks the 8th (final) sample of a frame
- frame_re  out  8*DW  real parts; slot k at bits [k*DW +: DW] → FFT xkr
- frame_im  out  8*DW  imaginary parts; slot k at bits [k*DW +: DW] → FFT xki
- frame_valid  out  1  frame_re/frame_im hold a complete frame
- frame_ready  in  1  consumer takes the frame this cycle
- frame_err  out  1  one-cycle pulse on s_last misalignment

## Operation
- State:
  - two banks, each 8 × (re, im) registers
  - full[1:0]
  - wr_bank, wr_idx[2:0]
  - rd_bank
  - frame_err register
- Accept = s_valid && s_ready. s_ready = !full[wr_bank], a pure register decode. There is no combinational path from frame_ready or s_valid to s_ready.
- On accept: write s_re/s_im into bank[wr_bank] slot wr_idx.
  - wr_idx < 7 with s_last=0: wr_idx++.
  - wr_idx = 7: set full[wr_bank], toggle wr_bank, wr_idx ← 0 (commit).
  - wr_idx = 7 with s_last=0: commit anyway, pulse frame_err.
  - wr_idx < 7 with s_last=1: the partial frame is discarded. The sample is written but the bank is not marked full, wr_idx ← 0, wr_bank unchanged, frame_err pulses.
- Read side: frame_valid = full[rd_bank]. frame_re/frame_im are muxed from bank[rd_bank] registers.
  - On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank.
- Simultaneous commit of one bank and release of the other in the same cycle: both take effect.
- When both banks are full: s_ready=0. The next release re-asserts s_ready in the following cycle.
- frame_ready while frame_valid=0 is ignored.
- No arithmetic. Data passes bit-exact; no scaling or saturation.

## Timing
- Reset (async assert, removal synchronous to clk):
  - all bank registers 0, full=00, wr_bank=0, rd_bank=0, wr_idx=0
  - s_ready=1, frame_valid=0, frame_err=0, frame_re/frame_im=0
- Latency: 8th sample accepted at edge T → frame_valid=1 from T (visible in cycle T+1). The FFT outputs are valid combinationally in that same cycle.
- Hold: frame_re/frame_im/frame_valid stay constant from assertion until the handshake edge. The rd_bank data is never overwritten while full.
- Throughput: one sample per cycle sustained, one frame per 8 cycles, when frame_ready is held high.
- frame_err: high for exactly the cycle after the offending accept edge.
- Reset mid-frame or with banks full: all partial and held data is dropped and the block returns to the reset state.

## Test plan
- Basic frame: after reset, send samples re=k+1, im=-(k+1) for k=0..7 (s_last on k=7), frame_ready=0.
  - s_ready stays 1, frame_valid=1 after the 8th edge.
  - slot k re=k+1, im=-(k+1).
  - frame_err never pulses.
- Ping-pong backpressure: frame_ready=0, stream 16 samples then a 17th offered.
  - 16 accepted, frame_valid=1, s_ready=0 after sample 16, sample 17 stalled.
  - Pulse frame_ready one cycle → frame 1 released, frame 2 (values 9..16) presented next cycle, s_ready=1, sample 17 accepted.
- Streaming: frame_ready=1, s_valid=1 for 64 cycles with an incrementing counter.
  - 8 frames delivered, one frame_valid handshake every 8 cycles, s_ready never drops.
  - data matches 0..63 in order.
- Early s_last: s_last on the 5th sample, then a clean 8-sample frame of values 100..107.
  - frame_err pulses once, no frame emitted for the partial data.
  - next frame holds 100..107 in slots 0..7.
- Missing s_last: 8 samples with s_last=0 → frame committed and valid, frame_err pulses once in the cycle after the 8th accept.
- Async reset: assert rst_n=0 mid-way (3 samples in, one bank full) between clock edges.
  - Outputs immediately return to reset values, s_ready=1, frame_valid=0.
  - A fresh 8-sample frame after release lands in slots 0..7.

Source files
------------

// File: rtl/fft8_input_framer.sv
// Serial-to-parallel framer for the 8-point FFT: collects 8 complex samples per frame
// into a ping-pong register bank pair and presents the held bank in natural slot order.
module fft8_input_framer #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_re,
  input  logic [DW-1:0]   s_im,
  input  logic            s_last,
  output logic [8*DW-1:0] frame_re,
  output logic [8*DW-1:0] frame_im,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic            frame_err
);

  logic [DW-1:0] bank_re [0:1][0:7];
  logic [DW-1:0] bank_im [0:1][0:7];
  logic [1:0]    full;
  logic          wr_bank;
  logic [2:0]    wr_idx;
  logic          rd_bank;
  logic          err_q;

  logic [1:0]    full_next;
  logic          wr_bank_next;
  logic [2:0]    wr_idx_next;
  logic          rd_bank_next;
  logic          err_next;
  logic          accept;
  logic          rd_take;

  // s_ready and frame_valid decode registers only, so neither handshake side sees the other combinationally
  assign s_ready     = ~full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign frame_err   = err_q;
  assign accept      = s_valid & s_ready;
  assign rd_take     = frame_valid & frame_ready;

  // Next-state for occupancy, bank pointers, write index and misalignment flag
  always_comb begin
    full_next    = full;
    wr_bank_next = wr_bank;
    wr_idx_next  = wr_idx;
    rd_bank_next = rd_bank;
    err_next     = 1'b0;
    if (rd_take) begin
      full_next[rd_bank] = 1'b0;
      rd_bank_next       = ~rd_bank;
    end else begin
      rd_bank_next = rd_bank;
    end
    if (accept) begin
      if (wr_idx == 3'd7) begin
        // Slot 7 always commits; a missing s_last only raises the error flag
        full_next[wr_bank] = 1'b1;
        wr_bank_next       = ~wr_bank;
        wr_idx_next        = 3'd0;
        err_next           = ~s_last;
      end else if (s_last) begin
        wr_idx_next = 3'd0;
        err_next    = 1'b1;
      end else begin
        wr_idx_next = wr_idx + 3'd1;
      end
    end else begin
      wr_idx_next = wr_idx;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= 3'd0;
      rd_bank <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      full    <= full_next;
      wr_bank <= wr_bank_next;
      wr_idx  <= wr_idx_next;
      rd_bank <= rd_bank_next;
      err_q   <= err_next;
    end
  end

  // Sample storage; only the bank being filled is ever written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_re[b][k] <= {DW{1'b0}};
          bank_im[b][k] <= {DW{1'b0}};
        end
      end
    end else if (accept) begin
      bank_re[wr_bank][wr_idx] <= s_re;
      bank_im[wr_bank][wr_idx] <= s_im;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_re[b][k] <= bank_re[b][k];
          bank_im[b][k] <= bank_im[b][k];
        end
      end
    end
  end

  // Parallel presentation of the read bank, slot k at bits [k*DW +: DW]
  always_comb begin
    frame_re = {8*DW{1'b0}};
    frame_im = {8*DW{1'b0}};
    for (int k = 0; k < 8; k++) begin
      frame_re[k*DW +: DW] = bank_re[rd_bank][k];
      frame_im[k*DW +: DW] = bank_im[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fft8_input_framer.sv
// Directed bench for fft8_input_framer: framing, ping-pong backpressure, streaming,
// s_last misalignment handling and asynchronous reset.
module tb_fft8_input_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_re;
  logic [15:0]  s_im;
  logic         s_last;
  logic [127:0] frame_re;
  logic [127:0] frame_im;
  logic         frame_valid;
  logic         frame_ready;
  logic         frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft8_input_framer #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .frame_re(frame_re), .frame_im(frame_im), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_err(frame_err)
  );

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_re = 16'd0; s_im = 16'd0; s_last = 1'b0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One offered sample for one clock; acc reports whether it was taken at that edge
  task automatic push(input logic [15:0] re, input logic [15:0] im, input logic last, output logic acc);
    s_valid = 1'b1; s_re = re; s_im = im; s_last = last;
    acc = s_ready;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (s_ready !== 1'b1 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: s_ready=%b frame_valid=%b frame_err=%b, required 1 0 0", s_ready, frame_valid, frame_err);
    end
    n_cmp++;
    if (frame_re !== 128'd0 || frame_im !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_data: re=%h im=%h, required 0", frame_re, frame_im);
    end
  endtask

  task automatic test_basic();
    logic acc;
    int drops = 0;
    int errs = 0;
    logic [127:0] exp_re, exp_im;
    logic [15:0] v;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      v = 16'(k + 1);
      push(v, -v, k == 7, acc);
      exp_re[k*16 +: 16] = v;
      exp_im[k*16 +: 16] = -v;
      if (!acc) drops++;
      if (frame_err) errs++;
      if (k == 6) begin
        n_cmp++;
        if (frame_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_early_valid: frame_valid=%b after 7 samples, required 0", frame_valid);
        end
      end
    end
    n_cmp++;
    if (drops != 0 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_handshake: drops=%0d frame_valid=%b, required 0 1", drops, frame_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (frame_re[k*16 +: 16] !== exp_re[k*16 +: 16] || frame_im[k*16 +: 16] !== exp_im[k*16 +: 16]) begin
        n_bad++;
        $display("FAIL basic_slot%0d: re=%h im=%h, required %h %h", k, frame_re[k*16 +: 16], frame_im[k*16 +: 16],
                 exp_re[k*16 +: 16], exp_im[k*16 +: 16]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (frame_re !== exp_re || frame_im !== exp_im || frame_valid !== 1'b1 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_hold: re=%h valid=%b err=%b, required %h 1 0", frame_re, frame_valid, frame_err, exp_re);
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL basic_err: %0d frame_err pulses, required 0", errs);
    end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_release: frame_valid=%b s_ready=%b, required 0 1", frame_valid, s_ready);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int drops = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      push(16'(k + 1), 16'(k + 1), (k % 8) == 7, acc);
      if (!acc) drops++;
    end
    n_cmp++;
    if (drops != 0 || frame_valid !== 1'b1 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full: drops=%0d frame_valid=%b s_ready=%b, required 0 1 0", drops, frame_valid, s_ready);
    end
    // Offer sample 17 and hold it while the consumer is stalled
    s_valid = 1'b1; s_re = 16'd17; s_im = 16'd17; s_last = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (s_ready !== 1'b0 || frame_re[15:0] !== 16'd1 || frame_re[127:112] !== 16'd8) begin
      n_bad++;
      $display("FAIL bp_stall: s_ready=%b slot0=%0d slot7=%0d, required 0 1 8", s_ready, frame_re[15:0], frame_re[127:112]);
    end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b1 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_swap_ctrl: frame_valid=%b s_ready=%b, required 1 1", frame_valid, s_ready);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (frame_re[k*16 +: 16] !== 16'(k + 9)) begin
        n_bad++;
        $display("FAIL bp_frame2_slot%0d: re=%0d, required %0d", k, frame_re[k*16 +: 16], k + 9);
      end
    end
    acc = s_ready;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_accept17: accepted=%b, required 1", acc);
    end
    for (int k = 18; k <= 24; k++) push(16'(k), 16'(k), k == 24, acc);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_re[15:0] !== 16'd17 || frame_re[127:112] !== 16'd24) begin
      n_bad++;
      $display("FAIL bp_frame3: valid=%b slot0=%0d slot7=%0d, required 1 17 24", frame_valid, frame_re[15:0], frame_re[127:112]);
    end
  endtask

  task automatic test_streaming();
    int drops = 0;
    int f = 0;
    int last_i = 0;
    int bad_data = 0;
    int bad_gap = 0;
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        s_valid = 1'b1; s_re = 16'(i); s_im = ~16'(i); s_last = (i % 8) == 7;
        if (!s_ready) drops++;
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      @(posedge clk); #1;
      if (frame_valid) begin
        for (int k = 0; k < 8; k++) begin
          if (frame_re[k*16 +: 16] !== 16'(f*8 + k) || frame_im[k*16 +: 16] !== ~16'(f*8 + k)) bad_data++;
        end
        if (f > 0 && (i - last_i) != 8) bad_gap++;
        last_i = i;
        f++;
      end
    end
    frame_ready = 1'b0;
    n_cmp++;
    if (f != 8 || drops != 0) begin
      n_bad++;
      $display("FAIL stream_count: frames=%0d drops=%0d, required 8 0", f, drops);
    end
    n_cmp++;
    if (bad_data != 0 || bad_gap != 0) begin
      n_bad++;
      $display("FAIL stream_data: bad slots=%0d bad gaps=%0d, required 0 0", bad_data, bad_gap);
    end
  endtask

  task automatic test_early_last();
    logic acc;
    int errs = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(16'(50 + k), 16'(50 + k), k == 4, acc);
      if (frame_err) errs++;
    end
    n_cmp++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL early_pulse: frame_err=%b frame_valid=%b, required 1 0", frame_err, frame_valid);
    end
    for (int k = 0; k < 8; k++) begin
      push(16'(100 + k), 16'(100 + k), k == 7, acc);
      if (frame_err) errs++;
      if (k == 6) begin
        n_cmp++;
        if (frame_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL early_partial_emitted: frame_valid=%b, required 0", frame_valid);
        end
      end
    end
    n_cmp++;
    if (errs != 1 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL early_err_count: pulses=%0d frame_valid=%b, required 1 1", errs, frame_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (frame_re[k*16 +: 16] !== 16'(100 + k)) begin
        n_bad++;
        $display("FAIL early_slot%0d: re=%0d, required %0d", k, frame_re[k*16 +: 16], 100 + k);
      end
    end
  endtask

  task automatic test_missing_last();
    logic acc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push(16'(200 + k), 16'(300 + k), 1'b0, acc);
      if (k == 6) begin
        n_cmp++;
        if (frame_err !== 1'b0) begin
          n_bad++;
          $display("FAIL missing_early_err: frame_err=%b, required 0", frame_err);
        end
      end
    end
    n_cmp++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b1 || frame_re[127:112] !== 16'd207 || frame_im[15:0] !== 16'd300) begin
      n_bad++;
      $display("FAIL missing_commit: err=%b valid=%b slot7re=%0d slot0im=%0d, required 1 1 207 300",
               frame_err, frame_valid, frame_re[127:112], frame_im[15:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL missing_pulse_width: frame_err=%b, required 0", frame_err);
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    do_reset();
    for (int k = 0; k < 11; k++) push(16'(400 + k), 16'(400 + k), k == 7, acc);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_re !== 128'd0 || frame_im !== 128'd0) begin
      n_bad++;
      $display("FAIL async_reset: s_ready=%b valid=%b err=%b re=%h, required 1 0 0 0", s_ready, frame_valid, frame_err, frame_re);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) push(16'(500 + k), 16'(600 + k), k == 7, acc);
    n_cmp++;
    if (frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL async_refill_valid: frame_valid=%b, required 1", frame_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (frame_re[k*16 +: 16] !== 16'(500 + k) || frame_im[k*16 +: 16] !== 16'(600 + k)) begin
        n_bad++;
        $display("FAIL async_refill_slot%0d: re=%0d im=%0d, required %0d %0d", k, frame_re[k*16 +: 16],
                 frame_im[k*16 +: 16], 500 + k, 600 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_early_last();
    test_missing_last();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
